// File: rtl/zuart_txq.sv
// zuart_txq: power-of-two byte FIFO plus a two-state sequencer that feeds the
// UART transmitter, holding oTxEn high across back-to-back queued bytes.
module zuart_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iWrEn,
  input  logic [7:0]            iWrData,
  input  logic                  iFlush,
  input  logic                  iOvfClr,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [DEPTH_LOG2:0]   oCount,
  output logic                  oOvf,
  output logic                  oTxEn,
  output logic [7:0]            oTxData,
  input  logic                  iTxDone,
  output logic                  oBusy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stateT;

  stateT                 state, stateNext;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0]   countNext;
  logic                  fifoAvail, wrAccept, wrDrop, pop;

  // A flush makes the queue look empty this cycle, both to the sequencer and to writers.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    stateNext = state;
    pop       = 1'b0;
    fifoAvail = ~oEmpty & ~iFlush;
    wrAccept  = iWrEn & ~oFull & ~iFlush;
    wrDrop    = iWrEn & oFull & ~iFlush;

    case (state)
      IDLE: begin
        if (fifoAvail) begin
          pop       = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (iTxDone) begin
          if (fifoAvail) pop = 1'b1;
          else           stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (iFlush) countNext = '0;
    else        countNext = oCount + (DEPTH_LOG2 + 1)'(wrAccept) - (DEPTH_LOG2 + 1)'(pop);
  end

  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      oCount  <= '0;
      oEmpty  <= 1'b1;
      oFull   <= 1'b0;
      oOvf    <= 1'b0;
      oTxData <= 8'h00;
    end else begin
      if (iFlush)   rdPtr <= wrPtr;
      else if (pop) rdPtr <= rdPtr + PTR_ONE;
      if (wrAccept) wrPtr <= wrPtr + PTR_ONE;

      oCount <= countNext;
      oEmpty <= (countNext == '0);
      oFull  <= (countNext == FULL_CNT);

      // A dropped write wins over a clear in the same cycle.
      if (wrDrop)       oOvf <= 1'b1;
      else if (iOvfClr) oOvf <= 1'b0;

      if (pop) oTxData <= mem[rdPtr];
    end
  end

  // NOTE: the storage array is not reset; pointers and occupancy define what is valid, so stale contents are never observed.
  always_ff @(posedge iClk) begin
    if (wrAccept && !iRst) mem[wrPtr] <= iWrData;
  end

  assign oTxEn = (state == BUSY);
  assign oBusy = oTxEn | ~oEmpty;

endmodule

// File: tb/tb_zuart_txq.sv
// Self-checking bench for zuart_txq: a scoreboard queue holds bytes expected on
// the transmitter side; a monitor pops and compares each byte as it goes in flight.
module tb_zuart_txq;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                iClk = 1'b0;
  logic                iRst;
  logic                iWrEn;
  logic [7:0]          iWrData;
  logic                iFlush;
  logic                iOvfClr;
  logic                oFull;
  logic                oEmpty;
  logic [DEPTH_LOG2:0] oCount;
  logic                oOvf;
  logic                oTxEn;
  logic [7:0]          oTxData;
  logic                iTxDone;
  logic                oBusy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbq[$];

  zuart_txq #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWrEn   (iWrEn),
    .iWrData (iWrData),
    .iFlush  (iFlush),
    .iOvfClr (iOvfClr),
    .oFull   (oFull),
    .oEmpty  (oEmpty),
    .oCount  (oCount),
    .oOvf    (oOvf),
    .oTxEn   (oTxEn),
    .oTxData (oTxData),
    .iTxDone (iTxDone),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  // Inputs change 1 ns after the rising edge; outputs are read there or at the falling edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // A new byte goes in flight when oTxEn rises, or stays high after a sampled done pulse.
  initial begin : monitor
    logic       prevTxEn;
    logic       prevDone;
    logic [7:0] expByte;
    prevTxEn = 1'b0;
    prevDone = 1'b0;
    forever begin
      @(negedge iClk);
      if (oTxEn === 1'b1 && (!prevTxEn || prevDone)) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL tx_order: byte %02h went out, none expected", oTxData);
        end else begin
          expByte = sbq.pop_front();
          if (oTxData !== expByte) begin
            errors++;
            $display("FAIL tx_order: got %02h, expected %02h", oTxData, expByte);
          end
        end
      end
      checks++;
      if (oCount > DEPTH) begin
        errors++;
        $display("FAIL count_bound: got %0d, expected <= %0d", oCount, DEPTH);
      end
      prevTxEn = oTxEn;
      prevDone = iTxDone;
    end
  end

  task automatic drain(input int hold);
    int n;
    n = 0;
    while (!(oTxEn === 1'b0 && oEmpty === 1'b1) && n < 2000) begin
      if (oTxEn === 1'b1) begin
        repeat (hold) tick();
        iTxDone = 1'b1;
        tick();
        iTxDone = 1'b0;
        n += hold + 1;
      end else begin
        tick();
        n++;
      end
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles, expected < 2000", n);
    end
  endtask

  task automatic test_reset();
    checks += 7;
    if (oTxEn !== 1'b0)   begin errors++; $display("FAIL rst_txen: got %b, expected 0", oTxEn); end
    if (oCount !== '0)    begin errors++; $display("FAIL rst_count: got %0d, expected 0", oCount); end
    if (oEmpty !== 1'b1)  begin errors++; $display("FAIL rst_empty: got %b, expected 1", oEmpty); end
    if (oFull !== 1'b0)   begin errors++; $display("FAIL rst_full: got %b, expected 0", oFull); end
    if (oOvf !== 1'b0)    begin errors++; $display("FAIL rst_ovf: got %b, expected 0", oOvf); end
    if (oTxData !== 8'h0) begin errors++; $display("FAIL rst_data: got %02h, expected 00", oTxData); end
    if (oBusy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b, expected 0", oBusy); end
  endtask

  task automatic test_single();
    iWrEn = 1'b1; iWrData = 8'hA5; sbq.push_back(8'hA5);
    tick();
    iWrEn = 1'b0;
    checks += 3;
    if (oCount !== 5'd1) begin errors++; $display("FAIL single_count_k: got %0d, expected 1", oCount); end
    if (oTxEn !== 1'b0)  begin errors++; $display("FAIL single_txen_k: got %b, expected 0", oTxEn); end
    if (oBusy !== 1'b1)  begin errors++; $display("FAIL single_busy_k: got %b, expected 1", oBusy); end
    tick();
    checks += 3;
    if (oTxEn !== 1'b1)     begin errors++; $display("FAIL single_txen_k1: got %b, expected 1", oTxEn); end
    if (oTxData !== 8'hA5)  begin errors++; $display("FAIL single_data_k1: got %02h, expected a5", oTxData); end
    if (oCount !== 5'd0)    begin errors++; $display("FAIL single_count_k1: got %0d, expected 0", oCount); end
    repeat (2) tick();
    iTxDone = 1'b1;
    tick();
    iTxDone = 1'b0;
    checks += 2;
    if (oTxEn !== 1'b0) begin errors++; $display("FAIL single_txen_done: got %b, expected 0", oTxEn); end
    if (oBusy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b, expected 0", oBusy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      iWrEn = 1'b1; iWrData = seq[i]; sbq.push_back(seq[i]);
      tick();
    end
    iWrEn = 1'b0;
    checks++;
    if (oTxData !== 8'h11) begin errors++; $display("FAIL b2b_first: got %02h, expected 11", oTxData); end
    for (int j = 0; j < 3; j++) begin
      repeat (3) begin
        tick();
        checks++;
        if (oTxEn !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b, expected 1", oTxEn); end
      end
      iTxDone = 1'b1;
      tick();
      iTxDone = 1'b0;
      checks++;
      if (j < 2) begin
        if (oTxEn !== 1'b1 || oTxData !== seq[j+1]) begin
          errors++;
          $display("FAIL b2b_next: got en=%b data=%02h, expected en=1 data=%02h", oTxEn, oTxData, seq[j+1]);
        end
      end else if (oTxEn !== 1'b0) begin
        errors++;
        $display("FAIL b2b_fall: got %b, expected 0", oTxEn);
      end
    end
  endtask

  task automatic test_full_ovf();
    iTxDone = 1'b0;
    for (int i = 0; i < 18; i++) begin
      iWrEn = 1'b1; iWrData = 8'(i);
      if (i <= 16) sbq.push_back(8'(i));
      tick();
      if (i == 15) begin
        checks++;
        if (oCount !== 5'd15) begin errors++; $display("FAIL full_count15: got %0d, expected 15", oCount); end
      end
      if (i == 16) begin
        checks += 3;
        if (oCount !== 5'd16) begin errors++; $display("FAIL full_count16: got %0d, expected 16", oCount); end
        if (oFull !== 1'b1)   begin errors++; $display("FAIL full_flag: got %b, expected 1", oFull); end
        if (oOvf !== 1'b0)    begin errors++; $display("FAIL ovf_early: got %b, expected 0", oOvf); end
      end
      if (i == 17) begin
        checks += 2;
        if (oOvf !== 1'b1)    begin errors++; $display("FAIL ovf_set: got %b, expected 1", oOvf); end
        if (oCount !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d, expected 16", oCount); end
      end
    end
    iWrData = 8'hEE; iOvfClr = 1'b1;
    tick();
    iWrEn = 1'b0;
    checks++;
    if (oOvf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b, expected 1", oOvf); end
    tick();
    iOvfClr = 1'b0;
    checks++;
    if (oOvf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", oOvf); end
    drain(2);
    checks += 2;
    if (sbq.size() != 0) begin errors++; $display("FAIL full_drain: got %0d left, expected 0", sbq.size()); end
    if (oFull !== 1'b0)  begin errors++; $display("FAIL full_after: got %b, expected 0", oFull); end
  endtask

  task automatic test_wrap();
    int c;
    int sent;
    logic wr;
    c = 0;
    sent = 0;
    while (sent < 40 && c < 1000) begin
      iTxDone = (c % 5 == 4);
      wr = (c % 5 == 4) || (c % 10 == 1);
      iWrEn = wr;
      iWrData = 8'(8'h40 + sent);
      if (wr) begin
        sbq.push_back(8'(8'h40 + sent));
        sent++;
      end
      tick();
      c++;
    end
    iWrEn = 1'b0;
    iTxDone = 1'b0;
    drain(3);
    checks += 2;
    if (oOvf !== 1'b0)   begin errors++; $display("FAIL wrap_ovf: got %b, expected 0", oOvf); end
    if (sbq.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      iWrEn = 1'b1; iWrData = 8'(8'hC0 + i); sbq.push_back(8'(8'hC0 + i));
      tick();
    end
    iFlush = 1'b1; iWrData = 8'hEE;
    tick();
    iFlush = 1'b0; iWrEn = 1'b0;
    sbq.delete();
    checks += 4;
    if (oCount !== 5'd0)   begin errors++; $display("FAIL flush_count: got %0d, expected 0", oCount); end
    if (oEmpty !== 1'b1)   begin errors++; $display("FAIL flush_empty: got %b, expected 1", oEmpty); end
    if (oTxEn !== 1'b1)    begin errors++; $display("FAIL flush_inflight: got %b, expected 1", oTxEn); end
    if (oTxData !== 8'hC0) begin errors++; $display("FAIL flush_data: got %02h, expected c0", oTxData); end
    repeat (3) tick();
    checks++;
    if (oCount !== 5'd0) begin errors++; $display("FAIL flush_wr_drop: got %0d, expected 0", oCount); end
    iTxDone = 1'b1;
    tick();
    iTxDone = 1'b0;
    checks += 2;
    if (oTxEn !== 1'b0) begin errors++; $display("FAIL flush_done_en: got %b, expected 0", oTxEn); end
    if (oBusy !== 1'b0) begin errors++; $display("FAIL flush_done_busy: got %b, expected 0", oBusy); end

    iWrEn = 1'b1; iWrData = 8'hD0; sbq.push_back(8'hD0);
    tick();
    iWrData = 8'hD1; sbq.push_back(8'hD1);
    tick();
    iWrEn = 1'b0; iFlush = 1'b1; iTxDone = 1'b1;
    tick();
    iFlush = 1'b0; iTxDone = 1'b0;
    sbq.delete();
    checks += 2;
    if (oTxEn !== 1'b0)  begin errors++; $display("FAIL flush_done_same: got %b, expected 0", oTxEn); end
    if (oCount !== 5'd0) begin errors++; $display("FAIL flush_done_count: got %0d, expected 0", oCount); end
    tick();
    checks++;
    if (oTxEn !== 1'b0) begin errors++; $display("FAIL flush_no_reload: got %b, expected 0", oTxEn); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 18; i++) begin
      iWrEn = 1'b1; iWrData = 8'(8'h80 + i);
      if (i <= 16) sbq.push_back(8'(8'h80 + i));
      tick();
    end
    checks++;
    if (oOvf !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ovf: got %b, expected 1", oOvf); end
    iRst = 1'b1; iWrData = 8'h77; iTxDone = 1'b1;
    repeat (2) tick();
    iRst = 1'b0; iWrEn = 1'b0; iTxDone = 1'b0;
    sbq.delete();
    test_reset();
    tick();
    checks += 2;
    if (oTxEn !== 1'b0)  begin errors++; $display("FAIL rstmid_idle: got %b, expected 0", oTxEn); end
    if (oCount !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d, expected 0", oCount); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    iRst = 1'b1; iWrEn = 1'b0; iWrData = 8'h00;
    iFlush = 1'b0; iOvfClr = 1'b0; iTxDone = 1'b0;
    repeat (2) tick();
    iRst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_ovf();
    test_wrap();
    test_flush();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d, expected 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
